// File: rtl/fft_2d_8_pkg.sv
// Shared constants and FSM encoding for the 2-D FFT output serializer.
package fft_2d_8_pkg;
    localparam int N     = 8;
    localparam int NPT   = N * N;
    localparam int W_DEF = 16;
    localparam int IDX_W = 6;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;
endpackage

// File: rtl/fft_2d_8_out_serializer_if.sv
// Frame-in / sample-out bus of the serializer. Handshake: a beat moves on a
// rising edge where valid and ready are both 1; valid never waits on ready.
interface fft_2d_8_out_serializer_if #(
    parameter int W = fft_2d_8_pkg::W_DEF,
    parameter int N = fft_2d_8_pkg::N
);
    import fft_2d_8_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic [N*N*W-1:0]      in_frame_r;
    logic [N*N*W-1:0]      in_frame_i;
    logic                  out_valid;
    logic                  out_ready;
    logic signed [W-1:0]   out_r;
    logic signed [W-1:0]   out_i;
    logic [2:0]            out_row;
    logic [2:0]            out_col;
    logic                  out_last;

    modport master (
        output in_valid, in_frame_r, in_frame_i, out_ready,
        input  in_ready, out_valid, out_r, out_i, out_row, out_col, out_last
    );

    modport slave (
        input  in_valid, in_frame_r, in_frame_i, out_ready,
        output in_ready, out_valid, out_r, out_i, out_row, out_col, out_last
    );
endinterface

// File: rtl/fft_frame_buf.sv
// Capture buffer for one complex frame (real and imaginary banks) with an
// asynchronous read mux selected by the sample index.
module fft_frame_buf #(
    parameter int W   = fft_2d_8_pkg::W_DEF,
    parameter int NPT = fft_2d_8_pkg::NPT,
    parameter int AW  = fft_2d_8_pkg::IDX_W
) (
    input  logic                clk,
    input  logic                we,
    input  logic [NPT*W-1:0]    frame_r,
    input  logic [NPT*W-1:0]    frame_i,
    input  logic [AW-1:0]       rd_idx,
    output logic signed [W-1:0] sample_r,
    output logic signed [W-1:0] sample_i
);
    import fft_2d_8_pkg::*;

    logic [W-1:0] mem_r [NPT];
    logic [W-1:0] mem_i [NPT];

    // Contents are don't-care until the first capture, so no reset here.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int k = 0; k < NPT; k++) begin
                mem_r[k] <= frame_r[k*W +: W];
                mem_i[k] <= frame_i[k*W +: W];
            end
        end
    end

    assign sample_r = mem_r[rd_idx];
    assign sample_i = mem_i[rd_idx];
endmodule

// File: rtl/fft_2d_8_out_serializer.sv
// Captures a parallel N x N complex FFT frame and streams it out one sample
// per accepted beat in row-major order, with row/col tags and a last flag.
module fft_2d_8_out_serializer #(
    parameter int W = fft_2d_8_pkg::W_DEF,
    parameter int N = fft_2d_8_pkg::N
) (
    input  logic                           clk,
    input  logic                           rst_n,
    fft_2d_8_out_serializer_if.slave       bus,
    output logic [7:0]                     frame_cnt,
    output logic                           ovf,
    output fft_2d_8_pkg::state_t           fsm_state
);
    import fft_2d_8_pkg::*;

    localparam int PTS = N * N;
    localparam int IW  = $clog2(PTS);
    localparam logic [IW-1:0] LAST_IDX = IW'(PTS - 1);

    state_t              state, state_nxt;
    logic [IW-1:0]       idx, idx_nxt;
    logic                capture, xfer, at_last;
    logic signed [W-1:0] smp_r, smp_i;
    logic [IW-1:0]       row_full, col_full;

    fft_frame_buf #(.W(W), .NPT(PTS), .AW(IW)) u_buf (
        .clk      (clk),
        .we       (capture),
        .frame_r  (bus.in_frame_r),
        .frame_i  (bus.in_frame_i),
        .rd_idx   (idx),
        .sample_r (smp_r),
        .sample_i (smp_i)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            frame_cnt <= '0;
            ovf       <= 1'b0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            if (xfer && at_last) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
            // A frame offered while streaming is dropped; remember that it happened.
            if (state == SEND && bus.in_valid) begin
                ovf <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        capture   = 1'b0;
        xfer      = 1'b0;
        at_last   = (idx == LAST_IDX);
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    capture   = 1'b1;
                    idx_nxt   = '0;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (bus.out_ready) begin
                    xfer = 1'b1;
                    if (at_last) begin
                        idx_nxt   = '0;
                        state_nxt = IDLE;
                    end else begin
                        idx_nxt = idx + IW'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign row_full  = idx / IW'(N);
    assign col_full  = idx % IW'(N);
    assign fsm_state = state;

    // Sample outputs are gated to zero outside SEND so reset clears them at once.
    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.out_valid = (state == SEND);
        bus.out_r     = '0;
        bus.out_i     = '0;
        bus.out_row   = '0;
        bus.out_col   = '0;
        bus.out_last  = 1'b0;
        if (state == SEND) begin
            bus.out_r    = smp_r;
            bus.out_i    = smp_i;
            bus.out_row  = row_full[2:0];
            bus.out_col  = col_full[2:0];
            bus.out_last = at_last;
        end
    end
endmodule

// File: tb/tb_fft_2d_8_out_serializer.sv
// Directed bench for the 2-D FFT output serializer: per-beat model checks,
// a table of hand-computed samples, stalls, back-to-back frames, reset and wrap.
module tb_fft_2d_8_out_serializer;
    localparam int W   = 16;
    localparam int N   = 8;
    localparam int NPT = N * N;

    logic clk;
    logic rst_n;
    logic [7:0] frame_cnt;
    logic ovf;
    fft_2d_8_pkg::state_t fsm_state;

    fft_2d_8_out_serializer_if #(.W(W), .N(N)) bus ();

    fft_2d_8_out_serializer #(.W(W), .N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .frame_cnt (frame_cnt),
        .ovf       (ovf),
        .fsm_state (fsm_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         kind;
        int         idx;
        logic [W-1:0] r;
        logic [W-1:0] i;
        logic [2:0] row;
        logic [2:0] col;
        logic       last;
    } vec_t;

    vec_t             tbl[8];
    int               checks = 0;
    int               errors = 0;
    logic [NPT*W-1:0] frm_r, frm_i;
    logic [W-1:0]     exp_r [NPT];
    logic [W-1:0]     exp_i [NPT];
    logic [38:0]      got   [NPT];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // kind 0: real=k, imag=-k; kind 1: extremes at (7,7); kind 2: random.
    task automatic build_frame(input int kind);
        logic [W-1:0] vr, vi;
        for (int k = 0; k < NPT; k++) begin
            case (kind)
                0: begin vr = W'(k); vi = W'(-k); end
                1: begin
                    vr = (k == NPT - 1) ? 16'h8000 : W'(k);
                    vi = (k == NPT - 1) ? 16'h7fff : W'(k);
                end
                default: begin vr = W'($urandom); vi = W'($urandom); end
            endcase
            frm_r[k*W +: W] = vr;
            frm_i[k*W +: W] = vi;
            exp_r[k] = vr;
            exp_i[k] = vi;
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge of the idle gap.
    task automatic stream(input bit stall_mode, input bit keep_valid);
        int beat, cyc;
        bit stalled;
        logic [38:0] held, cur, want;
        bus.in_frame_r = frm_r;
        bus.in_frame_i = frm_i;
        bus.in_valid   = 1'b1;
        bus.out_ready  = 1'b1;
        beat = 0; cyc = 0; stalled = 0; held = '0;
        while (beat < NPT && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                bus.in_frame_r = ~frm_r;
                bus.in_frame_i = ~frm_i;
            end
            if (!keep_valid) bus.in_valid = 1'b0;
            check("send_state", {bus.out_valid, bus.in_ready}, 2'b10);
            if (!(bus.out_valid && !bus.in_ready)) break;
            cur = {bus.out_row, bus.out_col, bus.out_last, bus.out_r, bus.out_i};
            if (stalled) check("stall_hold", cur, held);
            bus.out_ready = stall_mode ? (cyc % 2 == 1) : 1'b1;
            if (bus.out_ready) begin
                want = {3'(beat / N), 3'(beat % N), (beat == NPT - 1), exp_r[beat], exp_i[beat]};
                check("beat", cur, want);
                got[beat] = cur;
                beat++;
                stalled = 0;
            end else begin
                held = cur;
                stalled = 1;
            end
        end
        check("beats_sent", beat, NPT);
        @(negedge clk);
        cyc++;
        check("idle_gap", {bus.out_valid, bus.in_ready, bus.out_last}, 3'b010);
        check("frame_cycles", cyc, stall_mode ? 128 : 65);
    endtask

    task automatic apply_table(input int kind);
        for (int t = 0; t < 8; t++) begin
            if (tbl[t].kind == kind) begin
                check("table", got[tbl[t].idx],
                      {tbl[t].row, tbl[t].col, tbl[t].last, tbl[t].r, tbl[t].i});
            end
        end
    endtask

    initial begin
        tbl[0] = '{0,  0, 16'h0000, 16'h0000, 3'd0, 3'd0, 1'b0};
        tbl[1] = '{0,  1, 16'h0001, 16'hffff, 3'd0, 3'd1, 1'b0};
        tbl[2] = '{0,  7, 16'h0007, 16'hfff9, 3'd0, 3'd7, 1'b0};
        tbl[3] = '{0,  8, 16'h0008, 16'hfff8, 3'd1, 3'd0, 1'b0};
        tbl[4] = '{0, 36, 16'h0024, 16'hffdc, 3'd4, 3'd4, 1'b0};
        tbl[5] = '{0, 63, 16'h003f, 16'hffc1, 3'd7, 3'd7, 1'b1};
        tbl[6] = '{1, 62, 16'h003e, 16'h003e, 3'd7, 3'd6, 1'b0};
        tbl[7] = '{1, 63, 16'h8000, 16'h7fff, 3'd7, 3'd7, 1'b1};

        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.in_frame_r = '0;
        bus.in_frame_i = '0;
        #1;
        check("rst_outputs", {bus.out_valid, bus.in_ready, bus.out_last, bus.out_r, bus.out_i,
                              bus.out_row, bus.out_col}, {3'b010, 38'd0});
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_ovf", ovf, 0);
        check("rst_state", fsm_state, fft_2d_8_pkg::IDLE);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Ramp frame, continuous ready.
        build_frame(0);
        stream(0, 0);
        apply_table(0);
        check("cnt_after_1", frame_cnt, 1);
        check("ovf_clean", ovf, 0);

        // Same frame with ready toggling 1,0,1,0.
        stream(1, 0);
        check("cnt_after_2", frame_cnt, 2);
        check("ovf_clean_2", ovf, 0);

        // in_valid held high: three frames back to back, last one with stalls.
        build_frame(0);
        stream(0, 1);
        check("ovf_set", ovf, 1);
        build_frame(2);
        stream(0, 1);
        build_frame(1);
        stream(1, 1);
        bus.in_valid = 1'b0;
        apply_table(1);
        check("cnt_after_5", frame_cnt, 5);
        check("ovf_sticky", ovf, 1);

        // Reset after 20 transfers of a frame.
        build_frame(0);
        bus.in_frame_r = frm_r;
        bus.in_frame_i = frm_i;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (20) @(negedge clk);
        check("pre_rst_pos", {bus.out_valid, bus.out_row, bus.out_col}, {1'b1, 3'd2, 3'd4});
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_out", {bus.out_valid, bus.in_ready, bus.out_last, bus.out_r, bus.out_i,
                              bus.out_row, bus.out_col}, {3'b010, 38'd0});
        check("mid_rst_cnt", frame_cnt, 0);
        check("mid_rst_ovf", ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;
        stream(0, 0);
        check("cnt_post_rst", frame_cnt, 1);

        // Counter wrap: 255 more frames.
        for (int f = 0; f < 254; f++) begin
            build_frame(2);
            stream(0, 0);
        end
        check("cnt_255", frame_cnt, 255);
        build_frame(2);
        stream(0, 0);
        check("cnt_wrap", frame_cnt, 0);
        check("ovf_final", ovf, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
